// File: rtl/led_seq_ctrl.sv
// Round-robin arbitrated LED pattern sequencer for the 8-LED bank.
// Optional macro LED_SEQ_ABORT_EN adds an abort input that cuts a running command short.
module led_seq_ctrl #(
  parameter int unsigned DWELL = 10000000
) (
  input  logic       clk,
  input  logic       rstn,
`ifdef LED_SEQ_ABORT_EN
  input  logic       abort,
`endif
  input  logic [1:0] req,
  input  logic [1:0] cmd_mode0,
  input  logic [3:0] cmd_loops0,
  input  logic [1:0] cmd_mode1,
  input  logic [3:0] cmd_loops1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       owner,
  output logic       done,
  output logic [7:0] led
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DWELL - 1);

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      step_q, step_d;
  logic [3:0]      pass_q, pass_d;
  logic [3:0]      loops_q, loops_d;
  logic [1:0]      mode_q, mode_d;
  logic            owner_q, owner_d;
  logic [7:0]      led_q, led_d;
  logic            aborted_q, aborted_d;
  logic [1:0]      gnt_c;
  logic            abort_req;

`ifdef LED_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // LED drive for step s of a pattern.
  function automatic logic [7:0] pattern(input logic [1:0] mode, input logic [2:0] s);
    logic [7:0] v;
    v = 8'h00;
    unique case (mode)
      2'd0: v = 8'h01 << s;
      2'd1: v = 8'h01 << {s[1:0], s[2]};  // evens first, then odds
      2'd2: v = 8'h01 << (~s);
      2'd3: v = s[0] ? 8'h00 : 8'hFF;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    pass_d    = pass_q;
    loops_d   = loops_q;
    mode_d    = mode_q;
    owner_d   = owner_q;
    led_d     = led_q;
    aborted_d = aborted_q;
    gnt_c     = 2'b00;
    unique case (state_q)
      StIdle: begin
        led_d     = 8'h00;
        aborted_d = 1'b0;
        if (req != 2'b00) begin
          // Both pending: the requester that did not go last wins.
          if (req == 2'b11) gnt_c = owner_q ? 2'b01 : 2'b10;
          else              gnt_c = req;
          owner_d = gnt_c[1];
          mode_d  = gnt_c[1] ? cmd_mode1 : cmd_mode0;
          loops_d = gnt_c[1] ? cmd_loops1 : cmd_loops0;
          cnt_d   = '0;
          step_d  = 3'd0;
          pass_d  = 4'd0;
          led_d   = pattern(mode_d, 3'd0);
          state_d = StRun;
        end
      end
      StRun: begin
        if (abort_req) begin
          state_d   = StGap;
          led_d     = 8'h00;
          aborted_d = 1'b1;
        end else if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (step_q == 3'd7) begin
            if (pass_q == loops_q) begin
              state_d = StGap;
              led_d   = 8'h00;
            end else begin
              pass_d = pass_q + 4'd1;
              step_d = 3'd0;
              led_d  = pattern(mode_q, 3'd0);
            end
          end else begin
            step_d = step_q + 3'd1;
            led_d  = pattern(mode_q, step_q + 3'd1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        led_d   = 8'h00;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      step_q    <= 3'd0;
      pass_q    <= 4'd0;
      loops_q   <= 4'd0;
      mode_q    <= 2'd0;
      owner_q   <= 1'b1;
      led_q     <= 8'h00;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      pass_q    <= pass_d;
      loops_q   <= loops_d;
      mode_q    <= mode_d;
      owner_q   <= owner_d;
      led_q     <= led_d;
      aborted_q <= aborted_d;
    end
  end

  // Grant is combinational from req, so mask it while reset is held.
  assign gnt   = gnt_c & {2{rstn}};
  assign busy  = (state_q == StRun) || (state_q == StGap);
  assign done  = (state_q == StGap) && !aborted_q;
  assign owner = owner_q;
  assign led   = led_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl (DWELL=4) using an expected-LED scoreboard queue.
module tb_led_seq_ctrl;

  localparam int unsigned DW = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       abort = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] cmd_mode0 = 2'd0;
  logic [3:0] cmd_loops0 = 4'd0;
  logic [1:0] cmd_mode1 = 2'd0;
  logic [3:0] cmd_loops1 = 4'd0;
  logic [1:0] gnt;
  logic       busy;
  logic       owner;
  logic       done;
  logic [7:0] led;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [1:0] gnt_exp_q[$];

  // Expected LED value, indexed mode*8 + step.
  logic [7:0] pat_tbl [32] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
    8'h01, 8'h04, 8'h10, 8'h40, 8'h02, 8'h08, 8'h20, 8'h80,
    8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
    8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00
  };

  always #5 clk = ~clk;

  led_seq_ctrl #(.DWELL(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
`ifdef LED_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .req        (req),
    .cmd_mode0  (cmd_mode0),
    .cmd_loops0 (cmd_loops0),
    .cmd_mode1  (cmd_mode1),
    .cmd_loops1 (cmd_loops1),
    .gnt        (gnt),
    .busy       (busy),
    .owner      (owner),
    .done       (done),
    .led        (led)
  );

  task automatic push_cmd(input int m, input int l);
    for (int p = 0; p <= l; p++)
      for (int s = 0; s < 8; s++)
        for (int d = 0; d < int'(DW); d++)
          exp_q.push_back(pat_tbl[m*8+s]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req  = 2'b00;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (led !== 8'h00 || busy !== 1'b0 || gnt !== 2'b00 || done !== 1'b0 || owner !== 1'b1) begin
      errors++;
      $display("FAIL reset_assert led=%h busy=%b gnt=%b done=%b owner=%b want 00 0 00 0 1",
               led, busy, gnt, done, owner);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (led !== 8'h00 || busy !== 1'b0 || gnt !== 2'b00 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d led=%h busy=%b gnt=%b done=%b want all zero",
                 i, led, busy, gnt, done);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] e;
    @(negedge clk);
    cmd_mode0 = 2'd0; cmd_loops0 = 4'd0; req = 2'b01;
    #1;
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b0 || led !== 8'h00) begin
      errors++;
      $display("FAIL single_grant gnt=%b busy=%b led=%h want 01 0 00", gnt, busy, led);
    end
    push_cmd(0, 0);
    @(negedge clk);
    req = 2'b00; cmd_mode0 = 2'd3; cmd_loops0 = 4'd5;  // must not affect the running command
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led !== e || busy !== 1'b1 || gnt !== 2'b00 || done !== 1'b0) begin
        errors++;
        $display("FAIL single_step led=%h busy=%b gnt=%b done=%b want %h 1 00 0",
                 led, busy, gnt, done, e);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || led !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gap done=%b led=%h busy=%b want 1 00 1", done, led, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || led !== 8'h00) begin
      errors++;
      $display("FAIL single_idle done=%b busy=%b led=%h want 0 0 00", done, busy, led);
    end
  endtask

  task automatic test_evenodd();
    logic [7:0] e;
    @(negedge clk);
    cmd_mode1 = 2'd1; cmd_loops1 = 4'd1; req = 2'b10;
    #1;
    checks++;
    if (gnt !== 2'b10) begin
      errors++;
      $display("FAIL evenodd_grant gnt=%b want 10", gnt);
    end
    push_cmd(1, 1);
    @(negedge clk);
    req = 2'b00; cmd_mode1 = 2'd2;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (led !== e || done !== 1'b0 || owner !== 1'b1) begin
        errors++;
        $display("FAIL evenodd_step led=%h done=%b owner=%b want %h 0 1", led, done, owner, e);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || led !== 8'h00) begin
      errors++;
      $display("FAIL evenodd_gap done=%b led=%h want 1 00", done, led);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL evenodd_once done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_contention();
    int now_c = 0;
    int last = 0;
    logic [1:0] e;
    do_reset();
    cmd_mode0 = 2'd0; cmd_loops0 = 4'd0; cmd_mode1 = 2'd1; cmd_loops1 = 4'd0;
    gnt_exp_q.push_back(2'b01); gnt_exp_q.push_back(2'b10);
    gnt_exp_q.push_back(2'b01); gnt_exp_q.push_back(2'b10);
    req = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      int waited = 0;
      while (gnt == 2'b00 && waited < 100) begin
        @(negedge clk);
        waited++;
        now_c++;
      end
      e = gnt_exp_q.pop_front();
      checks++;
      if (gnt !== e) begin
        errors++;
        $display("FAIL contention_gnt k=%0d gnt=%b want %b", k, gnt, e);
      end
      if (k > 0) begin
        checks++;
        if (now_c - last != 34) begin
          errors++;
          $display("FAIL contention_spacing k=%0d got %0d want 34", k, now_c - last);
        end
      end
      last = now_c;
      @(negedge clk);
      now_c++;
      checks++;
      if (owner !== e[1]) begin
        errors++;
        $display("FAIL contention_owner k=%0d owner=%b want %b", k, owner, e[1]);
      end
    end
    req = 2'b00;
  endtask

  task automatic test_reset_mid_run();
    int waited = 0;
    do_reset();
    cmd_mode1 = 2'd2; cmd_loops1 = 4'd0; req = 2'b10;
    #1;
    checks++;
    if (gnt !== 2'b10) begin
      errors++;
      $display("FAIL midrst_grant gnt=%b want 10", gnt);
    end
    @(negedge clk);
    req = 2'b00;
    while (led !== 8'h10 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (led !== 8'h10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_step3 led=%h busy=%b want 10 1", led, busy);
    end
    rstn = 1'b0;
    req  = 2'b10;
    #1;
    checks++;
    if (led !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || gnt !== 2'b00 || owner !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async led=%h busy=%b done=%b gnt=%b owner=%b want 00 0 0 00 1",
               led, busy, done, gnt, owner);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || led !== 8'h00) begin
        errors++;
        $display("FAIL midrst_held done=%b led=%h want 0 00", done, led);
      end
    end
    rstn = 1'b1;
    #1;
    checks++;
    if (gnt !== 2'b10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_regrant gnt=%b busy=%b want 10 0", gnt, busy);
    end
    @(negedge clk);
    req = 2'b00;
    checks++;
    if (led !== 8'h80 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_restart led=%h busy=%b want 80 1", led, busy);
    end
    do_reset();
  endtask

`ifdef LED_SEQ_ABORT_EN
  task automatic test_abort();
    do_reset();
    cmd_mode0 = 2'd3; cmd_loops0 = 4'd2; cmd_mode1 = 2'd0; cmd_loops1 = 4'd0;
    req = 2'b11;
    #1;
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("FAIL abort_grant gnt=%b want 01", gnt);
    end
    @(negedge clk);
    repeat (16) @(negedge clk);
    checks++;
    if (led !== 8'hFF) begin
      errors++;
      $display("FAIL abort_step4 led=%h want ff", led);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (led !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_step5 led=%h busy=%b want 00 1", led, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (led !== 8'h00 || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_gap led=%h done=%b busy=%b want 00 0 1", led, done, busy);
    end
    @(negedge clk);
    checks++;
    if (gnt !== 2'b10 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_next gnt=%b busy=%b done=%b want 10 0 0", gnt, busy, done);
    end
    req = 2'b00;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_evenodd();
    test_contention();
    test_reset_mid_run();
`ifdef LED_SEQ_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
